// File: rtl/ppi_pkg.sv
// Shared types and constants for the PPI bus master: FSM states, PPI register
// addresses and control-word bit positions.
package ppi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } ppi_state_t;

  localparam logic [1:0] PPI_PORT_A = 2'd0;
  localparam logic [1:0] PPI_PORT_B = 2'd1;
  localparam logic [1:0] PPI_PORT_C = 2'd2;
  localparam logic [1:0] PPI_CTRL   = 2'd3;

  // Control word: bit 7 set = mode-set word, clear = port C bit set/reset.
  localparam int PPI_CW_MODE_SET_BIT = 7;
  localparam int PPI_CW_BSR_SEL_LSB  = 1;
  localparam int PPI_CW_BSR_VAL_BIT  = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ppi_wait_counter.sv
// Loadable down-counter with zero flag; times the setup, strobe and hold
// phases of a PPI bus cycle. Saturates at zero.
module ppi_wait_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// Single-word initiator for the PPI chip bus with programmable setup/strobe/hold.
// Optional feature macro: PPI_CTRL_SHADOW_EN (control-word shadow, bus-less reads of address 3).
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic [1:0] A,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic [7:0] D_in
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  ppi_state_t state, state_nxt;
  logic       lat_write;
  logic [1:0] lat_addr;
  logic [7:0] lat_wdata;
  logic       accept, shadow_hit, capture_rd;
  logic       cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val;

  logic       wr_eff, bus_on;
  logic [1:0] addr_eff;
  logic [7:0] wdata_eff;
  logic       cs_n_nxt, rd_n_nxt, wr_n_nxt, d_oe_nxt, ready_nxt, rsp_valid_nxt;
  logic [1:0] a_nxt;
  logic [7:0] d_out_nxt;

  assign accept     = req_valid && req_ready;
  assign capture_rd = (state == STROBE) && cnt_zero && !lat_write;

  ppi_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clk      (clk),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .zero     (cnt_zero)
  );

`ifdef PPI_CTRL_SHADOW_EN
  logic [7:0] ctrl_shadow;
  assign shadow_hit = !req_write && (req_addr == PPI_CTRL);

  always_ff @(posedge clk) begin
    if (Reset) begin
      ctrl_shadow <= '0;
    end else if (accept && req_write && (req_addr == PPI_CTRL)) begin
      ctrl_shadow <= req_wdata;
    end
  end
`else
  assign shadow_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_load   = 1'b0;
    cnt_ld_val = SETUP_LD;
    case (state)
      IDLE: begin
        if (accept) begin
          if (shadow_hit) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SETUP;
            cnt_load  = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_nxt  = STROBE;
          cnt_load   = 1'b1;
          cnt_ld_val = STROBE_LD;
        end
      end
      STROBE: begin
        if (cnt_zero) begin
          state_nxt  = HOLD;
          cnt_load   = 1'b1;
          cnt_ld_val = HOLD_LD;
        end
      end
      HOLD:    if (cnt_zero) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the accept cycle's request
  // fields are forwarded directly instead of waiting for the latch.
  always_comb begin
    wr_eff        = accept ? req_write : lat_write;
    addr_eff      = accept ? req_addr  : lat_addr;
    wdata_eff     = accept ? req_wdata : lat_wdata;
    bus_on        = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
    cs_n_nxt      = !bus_on;
    rd_n_nxt      = !((state_nxt == STROBE) && !wr_eff);
    wr_n_nxt      = !((state_nxt == STROBE) && wr_eff);
    a_nxt         = bus_on ? addr_eff : 2'd0;
    d_oe_nxt      = bus_on && wr_eff;
    d_out_nxt     = d_oe_nxt ? wdata_eff : 8'h00;
    ready_nxt     = (state_nxt == IDLE);
    rsp_valid_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      CS_n      <= 1'b1;
      RD_n      <= 1'b1;
      WR_n      <= 1'b1;
      A         <= 2'd0;
      D_out     <= 8'h00;
      D_oe      <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= 2'd0;
      lat_wdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      req_ready <= ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      CS_n      <= cs_n_nxt;
      RD_n      <= rd_n_nxt;
      WR_n      <= wr_n_nxt;
      A         <= a_nxt;
      D_out     <= d_out_nxt;
      D_oe      <= d_oe_nxt;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      rsp_rdata <= 8'h00;
    end else if (capture_rd) begin
      rsp_rdata <= D_in;
`ifdef PPI_CTRL_SHADOW_EN
    end else if (accept && shadow_hit) begin
      rsp_rdata <= ctrl_shadow;
`endif
    end
  end

endmodule

// File: tb/tb_ppi_bus_master.sv
// Randomized scoreboard bench for ppi_bus_master: a driver issues requests and
// queues expectations, a monitor compares bus pins and responses every cycle.
module tb_ppi_bus_master;

  localparam int S = 1;
  localparam int T = 2;
  localparam int H = 1;
`ifdef PPI_CTRL_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  localparam logic [15:0] IDLE_V = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
  localparam logic [15:0] RST_V  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00};

  typedef struct {
    int         c0;
    bit         w;
    logic [1:0] a;
    logic [7:0] wd;
    logic [7:0] rd;
    bit         sh;
  } txn_t;

  logic       clk, Reset, req_valid, req_ready, req_write, rsp_valid;
  logic [1:0] req_addr, A;
  logic [7:0] req_wdata, rsp_rdata, D_out, D_in;
  logic       CS_n, RD_n, WR_n, D_oe;

  logic       u2_rst, u2_valid, u2_ready, u2_write, u2_rsp_valid;
  logic [1:0] u2_addr, u2_A;
  logic [7:0] u2_wdata, u2_rdata, u2_D_out, u2_D_in;
  logic       u2_CS_n, u2_RD_n, u2_WR_n, u2_D_oe;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  int   cap_cyc = -100;
  logic [7:0] cap_val = 8'h00;
  logic [7:0] rd_m = 8'h00;
  logic [7:0] sh_m = 8'h00;
  txn_t exp_q[$];

  ppi_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
    .clk(clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .CS_n(CS_n), .RD_n(RD_n),
    .WR_n(WR_n), .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
  );

  ppi_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) dut2 (
    .clk(clk), .Reset(u2_rst), .req_valid(u2_valid), .req_ready(u2_ready),
    .req_write(u2_write), .req_addr(u2_addr), .req_wdata(u2_wdata),
    .rsp_valid(u2_rsp_valid), .rsp_rdata(u2_rdata), .CS_n(u2_CS_n), .RD_n(u2_RD_n),
    .WR_n(u2_WR_n), .A(u2_A), .D_out(u2_D_out), .D_oe(u2_D_oe), .D_in(u2_D_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  // The PPI only presents the read value in the last strobe cycle.
  always @(negedge clk)
    D_in = (cyc == cap_cyc) ? cap_val : (cap_val ^ 8'($urandom_range(1, 255)));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected pins {ready, rsp_valid, CS_n, RD_n, WR_n, D_oe, A, D_out} in cycle k after accept.
  function automatic logic [15:0] exp_vec(input int ns, input int nt, input int nh, input int k,
                                          input bit w, input logic [1:0] a,
                                          input logic [7:0] wd, input bit sh);
    int  len;
    bit  strb;
    len = ns + nt + nh;
    if (k <= 0) return IDLE_V;
    if (sh) return (k == 1) ? {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00} : IDLE_V;
    if (k <= len) begin
      strb = (k > ns) && (k <= ns + nt);
      return {1'b0, 1'b0, 1'b0, !(strb && !w), !(strb && w), w, a, (w ? wd : 8'h00)};
    end
    if (k == len + 1) return {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
    return IDLE_V;
  endfunction

  function automatic logic [15:0] act_vec();
    return {req_ready, rsp_valid, CS_n, RD_n, WR_n, D_oe, A, D_out};
  endfunction

  function automatic logic [15:0] act_vec2();
    return {u2_ready, u2_rsp_valid, u2_CS_n, u2_RD_n, u2_WR_n, u2_D_oe, u2_A, u2_D_out};
  endfunction

  always @(negedge clk) begin
    logic [15:0] e;
    int   k;
    bit   fin;
    txn_t t;
    if (mon_en) begin
      e   = IDLE_V;
      fin = 1'b0;
      if (exp_q.size() > 0) begin
        t   = exp_q[0];
        k   = cyc - t.c0;
        e   = exp_vec(S, T, H, k, t.w, t.a, t.wd, t.sh);
        fin = (k == (t.sh ? 1 : S + T + H + 1));
      end
      check("bus_pins", 32'(act_vec()), 32'(e));
      if (fin) begin
        check("rsp_rdata", 32'(rsp_rdata), 32'(t.rd));
        t = exp_q.pop_front();
      end
    end
  end

  task automatic issue(input bit w, input logic [1:0] a, input logic [7:0] wd,
                       input logic [7:0] dv, input bit hold, output int c0_out);
    int   n;
    txn_t t;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      n_chk++;
      $display("FAIL accept_timeout: req_ready got %b required 1 within 60 cycles", req_ready);
      req_valid = 1'b0;
      c0_out = -1;
      return;
    end
    t.c0 = cyc; t.w = w; t.a = a; t.wd = wd;
    t.sh = SHADOW && !w && (a == 2'd3);
    if (!w && !t.sh) begin
      cap_cyc = cyc + S + T;
      cap_val = dv;
    end
    t.rd = w ? rd_m : (t.sh ? sh_m : dv);
    rd_m = t.rd;
    if (SHADOW && w && (a == 2'd3)) sh_m = wd;
    exp_q.push_back(t);
    c0_out = t.c0;
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    int  c0, prev_c0, prev_done;
    bit  prev_hold, w, hold, sh;
    logic [1:0] a;
    logic [7:0] wd, dv;

    Reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0; req_wdata = 8'h00;
    u2_rst = 1'b1; u2_valid = 1'b0; u2_write = 1'b0; u2_addr = 2'd0; u2_wdata = 8'h00;
    u2_D_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_pins", 32'(act_vec()), 32'(RST_V));
    check("reset_rdata", 32'(rsp_rdata), 32'h0);
    Reset = 1'b0;
    @(negedge clk);
    check("reset_release_pins", 32'(act_vec()), 32'(IDLE_V));
    mon_en = 1'b1;

    issue(1'b0, 2'd1, 8'h00, 8'h5A, 1'b0, c0);
    issue(1'b1, 2'd3, 8'h80, 8'h00, 1'b1, prev_c0);
    issue(1'b1, 2'd3, 8'h9B, 8'h00, 1'b1, c0);
    check("b2b_accept", 32'(c0 - prev_c0), 32'(S + T + H + 2));
    prev_c0 = c0;
    issue(1'b0, 2'd3, 8'h00, 8'h3C, 1'b0, c0);
    check("b2b_accept", 32'(c0 - prev_c0), 32'(S + T + H + 2));

    prev_hold = 1'b0; prev_c0 = 0; prev_done = 0;
    for (int i = 0; i < 150; i++) begin
      w    = 1'($urandom_range(0, 1));
      a    = 2'($urandom_range(0, 3));
      wd   = 8'($urandom);
      dv   = 8'($urandom);
      hold = 1'($urandom_range(0, 1));
      issue(w, a, wd, dv, hold, c0);
      if (prev_hold) check("b2b_accept", 32'(c0 - prev_c0), 32'(prev_done + 1));
      sh        = SHADOW && !w && (a == 2'd3);
      prev_hold = hold;
      prev_c0   = c0;
      prev_done = sh ? 1 : S + T + H + 1;
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_queue", 32'(exp_q.size()), 32'h0);

    // Abort a read in its second strobe cycle.
    mon_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2;
    check("pre_abort_ready", 32'(req_ready), 32'h1);
    c0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    while (cyc < c0 + S + 2) @(negedge clk);
    check("abort_strobe_low", 32'(RD_n), 32'h0);
    Reset = 1'b1;
    @(negedge clk);
    check("abort_pins", 32'(act_vec()), 32'(RST_V));
    check("abort_rdata", 32'(rsp_rdata), 32'h0);
    Reset = 1'b0;
    rd_m = 8'h00; sh_m = 8'h00;
    @(negedge clk);
    check("abort_release_pins", 32'(act_vec()), 32'(IDLE_V));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'h0);
    end
    mon_en = 1'b1;
    issue(1'b0, 2'd3, 8'h00, 8'hA7, 1'b0, c0);
    issue(1'b1, 2'd0, 8'h11, 8'h00, 1'b0, c0);
    issue(1'b0, 2'd0, 8'h00, 8'hE4, 1'b0, c0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_queue", 32'(exp_q.size()), 32'h0);
    mon_en = 1'b0;

    // Long-phase instance: SETUP 3, STROBE 4, HOLD 2.
    u2_rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    u2_valid = 1'b1; u2_write = 1'b0; u2_addr = 2'd1;
    for (int k = 0; k <= 12; k++) begin
      if (k == 1) u2_valid = 1'b0;
      u2_D_in = (k == 7) ? 8'hC3 : (8'hC3 ^ 8'($urandom_range(1, 255)));
      check("long_bus_pins", 32'(act_vec2()), 32'(exp_vec(3, 4, 2, k, 1'b0, 2'd1, 8'h00, 1'b0)));
      if (k == 10) check("long_rdata", 32'(u2_rdata), 32'hC3);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
